// File: rtl/store_pkg.sv
// Shared encodings for the store formatter: access sizes, FSM states and timeout.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CNT_W       = 4;

  // True when the register value survives truncation to the access width as a signed value.
  function automatic logic fits_signed(input logic [31:0] data, input size_e size);
    case (size)
      SZ_BYTE: return (&data[31:7]) | ~(|data[31:7]);
      SZ_HALF: return (&data[31:15]) | ~(|data[31:15]);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Combinational lane placement: replicated write data, byte enables and alignment check.
module store_lane_mux
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misalign_o
);

  always_comb begin
    wdata_o    = '0;
    be_o       = '0;
    misalign_o = 1'b0;
    case (size_e'(size_i))
      SZ_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o    = {2{data_i[15:0]}};
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        wdata_o    = data_i;
        be_o       = '1;
        misalign_o = |addr_lo_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_formatter.sv
// Store formatter: turns MEM-stage store requests into a held memory write request.
// Optional narrowing check enabled by defining STORE_NARROW_CHECK_EN.
module store_formatter
  import store_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        exc_misalign,
  output logic        exc_timeout,
  output logic        exc_narrow
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               done_q, done_d;
  logic               misalign_q, misalign_d;
  logic               timeout_q, timeout_d;

  logic [31:0]        lane_wdata;
  logic [3:0]         lane_be;
  logic               lane_misalign;
  logic               accept;

  store_lane_mux u_lane_mux (
    .addr_lo_i  (in_addr[1:0]),
    .size_i     (in_size),
    .data_i     (in_data),
    .wdata_o    (lane_wdata),
    .be_o       (lane_be),
    .misalign_o (lane_misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (lane_misalign) begin
            misalign_d = 1'b1;
          end else begin
            accept  = 1'b1;
            addr_d  = {in_addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Ack wins over timeout on the final allowed cycle.
        if (mem_ack) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // mem_req follows the state flop directly so reset clears it asynchronously.
  assign in_ready     = (state_q == ST_IDLE);
  assign mem_req      = (state_q == ST_REQ);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign done         = done_q;
  assign exc_misalign = misalign_q;
  assign exc_timeout  = timeout_q;

`ifdef STORE_NARROW_CHECK_EN
  logic narrow_q, narrow_d;

  always_comb begin
    narrow_d = accept & ~fits_signed(in_data, size_e'(in_size));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) narrow_q <= 1'b0;
    else       narrow_q <= narrow_d;
  end

  assign exc_narrow = narrow_q;
`else
  assign exc_narrow = 1'b0;
`endif

endmodule
